mux_serializer: RTL

Parametrised N-to-1 selector with a registered output and an auto-scan serializer mode.
- Manual mode: behaves as a registered N:1 mux, Y = D[S] one clock later.
- Scan mode: captures D on start and emits its N bits serially, one per accepted transfer, under a valid/ready handshake.
- Sits between parallel status/data words and single-bit serial links or debug pins.

---
 rtl/mux_pkg.sv | 13 +
 rtl/mux_nx1.sv | 21 ++
 rtl/mux_serializer.sv | 100 ++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared encodings for the mux/serializer block.
package mux_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_nx1.sv
// Combinational N:1 bit selector; any select value >= N yields 0.
module mux_nx1 #(
    parameter int unsigned N  = 16,
    parameter int unsigned SW = $clog2(N)
) (
    input  logic [N-1:0]  d,
    input  logic [SW-1:0] sel,
    output logic          y_c
);

    // Compare against each legal index so out-of-range selects fall through to 0.
    always_comb begin
        y_c = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (sel == SW'(i)) begin
                y_c = d[i];
            end
        end
    end

endmodule

// File: rtl/mux_serializer.sv
// Registered N:1 mux with an auto-scan serializer mode behind a valid/ready handshake.
module mux_serializer
    import mux_pkg::*;
#(
    parameter int unsigned N         = 16,
    parameter int unsigned SW        = $clog2(N),
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  D,
    input  logic [SW-1:0] S,
    input  logic          mode,
    input  logic          start,
    input  logic          ready,
    output logic          Y,
    output logic          valid,
    output logic          busy,
    output logic          done
);

    localparam int unsigned FIRST_I = MSB_FIRST ? N - 1 : 0;
    localparam int unsigned LAST_I  = MSB_FIRST ? 0 : N - 1;
    localparam logic [SW-1:0] FIRST = SW'(FIRST_I);
    localparam logic [SW-1:0] LAST  = SW'(LAST_I);

    state_t        state;
    logic [SW-1:0] idx;
    logic [N-1:0]  shadow;
    logic [SW-1:0] idx_step;
    logic          man_y_c;
    logic          scan_y_c;

    // Only used when idx != LAST, so the step never wraps.
    assign idx_step = MSB_FIRST ? idx - SW'(1) : idx + SW'(1);

    mux_nx1 #(.N(N), .SW(SW)) u_man_mux (
        .d   (D),
        .sel (S),
        .y_c (man_y_c)
    );

    mux_nx1 #(.N(N), .SW(SW)) u_scan_mux (
        .d   (shadow),
        .sel (idx_step),
        .y_c (scan_y_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            shadow <= '0;
            Y      <= 1'b0;
            valid  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mode == MODE_MANUAL) begin
                        Y <= man_y_c;
                    end else if (start) begin
                        shadow <= D;
                        Y      <= D[FIRST_I];
                        idx    <= FIRST;
                        valid  <= 1'b1;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    // valid is always set here, so ready alone marks a transfer.
                    if (ready) begin
                        if (idx == LAST) begin
                            valid <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            idx <= idx_step;
                            Y   <= scan_y_c;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
